// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration frame loader.
//   cfg_state_e : loader FSM states
//   SYNC_BYTE   : byte that opens a bitstream
//   POST_BYTE   : byte that must close a bitstream
//   CHK_W       : width of the running per-frame XOR checksum
package cfg_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_WRITE,
    ST_POST,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hF2;
  localparam logic [7:0] POST_BYTE = 8'h0F;
  localparam int         CHK_W     = 8;

endpackage

// File: rtl/cfg_frame_asm.sv
// Frame assembler: places payload bytes into the frame word (first byte in
// the LSBs), keeps the running XOR checksum and flags the last byte slot.
//   CLK, RST   : clock, asynchronous active-high reset
//   clr        : synchronous clear of byte counter and checksum
//   byte_en    : a payload byte is transferring this cycle
//   din        : payload byte
//   frame_data : assembled frame (held until overwritten)
//   chk        : XOR of the payload bytes of the current frame
//   last_byte  : the next payload byte completes the frame
module cfg_frame_asm
  import cfg_pkg::*;
#(
  parameter int FRAME_BITS = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  input  logic                  byte_en,
  input  logic [7:0]            din,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic [CHK_W-1:0]      chk,
  output logic                  last_byte
);

  localparam int BYTES = FRAME_BITS / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign last_byte = (cnt_q == CNT_W'(BYTES - 1));

  // frame_data is not touched by clr so the last written frame stays visible.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q      <= '0;
      chk        <= '0;
      frame_data <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      chk   <= '0;
    end else if (byte_en) begin
      frame_data[8*cnt_q +: 8] <= din;
      chk                      <= chk ^ din;
      cnt_q                    <= last_byte ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Configuration loader: parses a byte-serial bitstream
//   SYNC, LEN_HI, LEN_LO, { FRAME_BITS/8 payload bytes, checksum } x LEN, POST
// and issues one frame write per accepted frame.
//   CLK, RST       : clock, asynchronous active-high reset
//   CLEAR          : synchronous restart to IDLE, wins over a byte transfer
//   DIN/DIN_VALID  : byte input, DIN_READY is the loader's acceptance
//   FRAME_DATA     : assembled frame, FRAME_ADDR its slot, FRAME_WE strobe
//   FRAMES_LOADED  : frames written since the last SYNC byte
//   DONE / ERROR   : sticky load-complete / load-aborted status
//
// Handshake: a byte transfers on a rising CLK edge when DIN_VALID and
// DIN_READY are both 1 (and CLEAR is 0). DIN_READY depends only on the state,
// never on DIN_VALID; the source must hold DIN stable while DIN_VALID=1 and
// DIN_READY=0.
module cfg_frame_loader
  import cfg_pkg::*;
#(
  parameter int FRAME_BITS = 64,
  parameter int NUM_FRAMES = 32,
  parameter int ADDR_W     = $clog2(NUM_FRAMES)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CLEAR,
  input  logic [7:0]            DIN,
  input  logic                  DIN_VALID,
  output logic                  DIN_READY,
  output logic [FRAME_BITS-1:0] FRAME_DATA,
  output logic [ADDR_W-1:0]     FRAME_ADDR,
  output logic                  FRAME_WE,
  output logic [ADDR_W:0]       FRAMES_LOADED,
  output logic                  DONE,
  output logic                  ERROR
);

  cfg_state_e        state_q, state_d;
  logic [15:0]       len_q;
  logic [15:0]       len_full;
  logic [ADDR_W:0]   loaded_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CHK_W-1:0]  chk;
  logic              xfer, sync_hit, len_bad, chk_ok, last_frame;
  logic              asm_clr, asm_en, last_byte;

  assign xfer       = DIN_VALID && DIN_READY && !CLEAR;
  assign sync_hit   = (state_q == ST_IDLE) && xfer && (DIN == SYNC_BYTE);
  // LEN_LO decision uses the incoming low byte directly.
  assign len_full   = {len_q[15:8], DIN};
  assign len_bad    = (len_full == 16'd0) || (len_full > 16'(NUM_FRAMES));
  assign chk_ok     = (DIN == chk);
  assign last_frame = ((16'(loaded_q) + 16'd1) == len_q);

  assign asm_en  = xfer && (state_q == ST_DATA);
  assign asm_clr = !CLEAR && (sync_hit || (state_q == ST_WRITE));

  cfg_frame_asm #(
    .FRAME_BITS(FRAME_BITS)
  ) u_asm (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (asm_clr),
    .byte_en   (asm_en),
    .din       (DIN),
    .frame_data(FRAME_DATA),
    .chk       (chk),
    .last_byte (last_byte)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (CLEAR) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (sync_hit) state_d = ST_LEN_HI;
        ST_LEN_HI: if (xfer) state_d = ST_LEN_LO;
        ST_LEN_LO: if (xfer) state_d = len_bad ? ST_ERR : ST_DATA;
        ST_DATA:   if (xfer && last_byte) state_d = ST_CHECK;
        ST_CHECK:  if (xfer) state_d = chk_ok ? ST_WRITE : ST_ERR;
        ST_WRITE:  state_d = last_frame ? ST_POST : ST_DATA;
        ST_POST:   if (xfer) state_d = (DIN == POST_BYTE) ? ST_DONE : ST_ERR;
        ST_DONE:   state_d = ST_DONE;
        ST_ERR:    state_d = ST_ERR;
        default:   state_d = ST_ERR;
      endcase
    end
  end

  // Output decode
  always_comb begin
    DIN_READY = 1'b0;
    FRAME_WE  = 1'b0;
    DONE      = 1'b0;
    ERROR     = 1'b0;
    case (state_q)
      ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHECK, ST_POST: DIN_READY = 1'b1;
      ST_WRITE: FRAME_WE = 1'b1;
      ST_DONE:  DONE     = 1'b1;
      ST_ERR:   ERROR    = 1'b1;
      default:  ;
    endcase
  end

  // LEN, frame counter and write address. The address is captured when the
  // checksum matches so it stays on the written slot after the counter moves.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_q    <= '0;
      loaded_q <= '0;
      addr_q   <= '0;
    end else if (!CLEAR) begin
      if (sync_hit) loaded_q <= '0;
      if ((state_q == ST_LEN_HI) && xfer) len_q[15:8] <= DIN;
      if ((state_q == ST_LEN_LO) && xfer) len_q[7:0]  <= DIN;
      if ((state_q == ST_CHECK) && xfer && chk_ok) addr_q <= loaded_q[ADDR_W-1:0];
      if (state_q == ST_WRITE) loaded_q <= loaded_q + 1'b1;
    end
  end

  assign FRAME_ADDR    = addr_q;
  assign FRAMES_LOADED = loaded_q;

endmodule

// File: doc/cfg_frame_loader.md
Name: cfg_frame_loader

Overview:
- Configuration controller that turns a byte-serial bitstream into frame writes for the fabric configuration memory.
- The configuration memory holds LUT INIT words, DFF ENABLE_USED/RST_USED bits and IOB INPUT/OUTPUT/ENABLE_USED bits.
- Checks sync byte, frame count, per-frame checksum and postamble, then writes one frame per write cycle.
- Sits between the external configuration port and the configuration memory; asserts DONE when the whole bitstream has loaded cleanly.

Parameters:
- FRAME_BITS, 64, width of one configuration frame; must be a multiple of 8.
- NUM_FRAMES, 32, number of frame slots in configuration memory; maximum legal LEN.
- ADDR_W, $clog2(NUM_FRAMES), width of FRAME_ADDR.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- CLEAR  in  1  synchronous restart to IDLE; takes effect from any state.
- DIN  in  8  bitstream byte.
- DIN_VALID  in  1  DIN is valid.
- DIN_READY  out  1  loader accepts DIN this cycle.
- FRAME_DATA  out  FRAME_BITS  assembled frame.
- FRAME_ADDR  out  ADDR_W  frame index.
- FRAME_WE  out  1  single-cycle write strobe.
- FRAMES_LOADED  out  ADDR_W+1  frames written since IDLE.
- DONE  out  1  load complete (sticky).
- ERROR  out  1  load aborted (sticky).

Behaviour:
- One clock domain (CLK). RST is asynchronous and active-high.
- Reset state: state=IDLE; FRAME_DATA, FRAME_ADDR, FRAME_WE, FRAMES_LOADED, DONE and ERROR all 0.
- DIN_READY is decoded combinationally from state. It is 1 in IDLE, LEN_HI, LEN_LO, DATA, CHECK and POST, and 0 in WRITE, DONE and ERR. It is therefore 1 out of reset.
- A byte transfers when DIN_VALID && DIN_READY.
- Constants: SYNC_BYTE=8'hF2, POST_BYTE=8'h0F.
- IDLE: accepted bytes other than SYNC_BYTE are dropped. SYNC_BYTE → LEN_HI; at the same time clear FRAMES_LOADED, the frame index, the byte counter and the checksum.
- LEN_HI: accepted byte → LEN[15:8]; next state LEN_LO.
- LEN_LO: accepted byte → LEN[7:0].
  - LEN==0 or LEN>NUM_FRAMES → ERR.
  - Otherwise → DATA.
- DATA: accepted byte k (k = 0 .. FRAME_BITS/8-1) goes to FRAME_DATA[8k+7:8k], so the first byte is the LSB. chk ^= byte. After the last byte → CHECK.
- CHECK: accepted byte compared with chk.
  - Equal → WRITE.
  - Different → ERR, with no write.
- WRITE: lasts exactly one cycle.
  - FRAME_WE=1, with FRAME_ADDR = frame index and FRAME_DATA stable.
  - Next edge: FRAMES_LOADED++, index++, chk and byte counter cleared.
  - If FRAMES_LOADED+1==LEN → POST, otherwise → DATA.
- POST: accepted byte == POST_BYTE → DONE, otherwise → ERR.
- DONE: DONE=1, accepts nothing. Leaves only on CLEAR or RST.
- ERR: ERROR=1, accepts nothing. Leaves only on CLEAR or RST.
- Latency: FRAME_WE is asserted in the cycle after the checksum byte transfers. Per frame, throughput is FRAME_BITS/8+2 cycles at full DIN_VALID.
- FRAME_WE is low in every state except WRITE.
- FRAME_DATA and FRAME_ADDR hold their last values outside WRITE.
- CLEAR has priority over any byte transfer in the same cycle. It forces IDLE, clears DONE and ERROR, and leaves FRAME_DATA untouched.
- RST in mid-frame discards the partial frame. Frames already written are not revoked.
- Checksum width is 8 bits. The frame index never wraps because LEN<=NUM_FRAMES.

Decomposition:
- Package cfg_pkg holds:
  - the state enum (IDLE, LEN_HI, LEN_LO, DATA, CHECK, WRITE, POST, DONE, ERR);
  - SYNC_BYTE and POST_BYTE;
  - the checksum width constant.
- Sub-module cfg_frame_asm: byte counter, FRAME_DATA shift/insert, running XOR, and a last_byte flag. The FSM, LEN register and frame counter stay in cfg_frame_loader.

Test Plan (FRAME_BITS=16, NUM_FRAMES=4):
- Stream 00,F2,00,02,11,22,33,AA,55,FF,0F at full VALID → FRAME_WE twice: addr0/16'h2211, then addr1/16'h55AA. Final state: DONE=1, ERROR=0, FRAMES_LOADED=2, DIN_READY=0.
- F2,00,01,11,22,00 (bad checksum) → ERROR=1, no FRAME_WE, FRAMES_LOADED=0. Then CLEAR=1 → IDLE, ERROR=0, DIN_READY=1.
- F2,00,00 and, separately, F2,00,05 → ERROR=1 after the LEN_LO byte.
- Valid LEN=1 frame followed by postamble 00 → one FRAME_WE, then ERROR=1 and FRAMES_LOADED=1.
- RST pulsed after F2,00,01,11 → all outputs 0, DIN_READY=1. Then the scenario-1 stream loads correctly.
- DIN_VALID toggling every other cycle, with the source holding a byte while DIN_READY=0 in WRITE → same writes as scenario 1, no byte lost or duplicated.
